seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//   Downstream display stage for the seven-segment seconds design. Takes a packed
//   multi-digit BCD/hex value and time-multiplexes it onto one shared 7-segment bus
//   with one-hot digit enables.
//   Adds per-slot dead time (anti-ghosting), optional leading-zero blanking, and
//   tear-free update: new values are applied only at frame boundaries.
// PARAMETERS
//   DIGITS        4     number of digits scanned (>=2)
//   SCAN_DIV      1000  clk cycles per digit slot (>BLANK_CYCLES)
//   BLANK_CYCLES  16    dead-time cycles at the start of each slot (>=1)
//   COMMON_ANODE  0     1: invert seg_out, dp_out and digit_en (active-low drive)
// PORTS
//   clk        in   1          system clock
//   rst        in   1          asynchronous reset, active high
//   ena        in   1          scan enable; low = hold counters, outputs inactive
//   value_in   in   4*DIGITS   nibble k = digit k (k=0 rightmost)
//   dp_in      in   DIGITS     decimal point per digit
//   load       in   1          1-cycle strobe: capture value_in/dp_in into shadow
//   lz_blank   in   1          1 = blank leading zero digits
//   seg_out    out  7          segments, bit0=a .. bit6=g
//   dp_out     out  1          decimal point of active digit
//   digit_en   out  DIGITS     one-hot active digit (all-off in dead time)
//   frame_done out  1          1-cycle pulse on last cycle of digit DIGITS-1 slot
// BEHAVIOUR
// - Reset (async): slot counter=0, digit index=0, state BLANK, shadow/display/dp
//   regs=0, pending=0. Outputs inactive: seg_out/dp_out/digit_en all 0, or all 1
//   when COMMON_ANODE=1. frame_done=0.
// - All outputs are registered; no combinational path from inputs to outputs.
// - Slot counter: counts 0..SCAN_DIV-1 and wraps.
//   - Width is $clog2(SCAN_DIV).
//   - Advances only while ena=1.
// - FSM:
//   - BLANK while count<BLANK_CYCLES; SHOW for the rest of the slot.
//   - At wrap: index=(index+1) mod DIGITS, return to BLANK.
// - BLANK: digit_en, seg_out and dp_out all inactive.
// - SHOW: digit_en[index] active. seg_out=decode(display nibble[index]); dp_out=dp reg[index].
// - Decode (active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F,
//   9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
// - Leading-zero blanking (lz_blank=1): digit k is blanked (seg_out=0, digit_en
//   still asserted) when nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked.
//   dp_out is unaffected.
// - load=1: shadow<=value_in, dp shadow<=dp_in, pending<=1. A repeated load overwrites.
// - Frame boundary (cycle where frame_done=1): if load, display<=value_in directly;
//   else if pending, display<=shadow. pending<=0 in both cases.
// - Latency: first SHOW of digit 0 at cycle BLANK_CYCLES after rst falls (ena=1).
// - ena=0 mid-slot: outputs inactive next cycle, counter/index frozen. On ena=1,
//   resumes from the frozen count. load is accepted regardless of ena.
// - rst mid-frame: outputs inactive immediately; any pending value is discarded.
// TESTING (DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 unless noted)
// - Reset: assert rst -> seg_out=00, digit_en=0000, frame_done=0. With COMMON_ANODE=1
//   -> seg_out=7F, digit_en=1111.
// - Scan timing: after load 16'h1234 and one frame -> each slot has 2 cycles
//   digit_en=0, then 6 cycles one-hot. Sequence: 0001 seg=66 ('4'), 0010 seg=4F,
//   0100 seg=5B, 1000 seg=06. frame_done pulses every 32 cycles.
// - Tear-free: load 16'h9999 mid-frame -> remaining digits still show 1234 values.
//   9s (seg=6F) appear from digit 0 of the next frame. Load on the frame_done cycle
//   -> that value is shown in the next frame.
// - lz_blank=1, value 16'h0050 -> digit3/digit2 seg=00 (en asserted), digit1=6D,
//   digit0=3F. Value 0000 -> only digit0 lit (3F).
// - ena dropped at count 4 of digit1 for 10 cycles -> outputs inactive. On resume,
//   digit1 shows for 4 more cycles, then digit2 slot starts.
// - rst pulse mid digit2 with a pending load -> outputs inactive. After release,
//   digit0 shows value 0 (3F) and the pending value is gone.

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Drives a shared seven-segment bus from a packed multi-digit hex value.
// Each digit owns a slot of SCAN_DIV clocks. The first BLANK_CYCLES clocks of a
// slot are dead time, which keeps the previous digit from ghosting onto the next.
// Leading zeros can be blanked. New values reach the display only at frame
// boundaries, so the digits of one frame always come from a single value.
`timescale 1ns/1ps
module seg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     LAST_COUNT = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     SHOW_START = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     LAST_INDEX = IW'(DIGITS - 1);

  // Inactive levels of the pin drivers; a common-anode board drives low to light.
  localparam logic [6:0]        SEG_OFF = {7{COMMON_ANODE}};
  localparam logic              DP_OFF  = COMMON_ANODE;
  localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{COMMON_ANODE}};

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Parameter sanity: stop elaboration on settings the scan timing cannot honour.
  generate
    if (DIGITS < 2) begin : g_bad_digits
      $error("seg_scan_mux: DIGITS must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
      $error("seg_scan_mux: BLANK_CYCLES must be at least 1");
    end
    if (SCAN_DIV <= BLANK_CYCLES) begin : g_bad_div
      $error("seg_scan_mux: SCAN_DIV must exceed BLANK_CYCLES");
    end
  endgenerate

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic [IW-1:0]        index;
  logic [IW-1:0]        index_next;
  logic                 slot_wrap;
  logic                 frame_wrap;
  logic                 last_next;

  logic [4*DIGITS-1:0]  shadow;
  logic [DIGITS-1:0]    shadow_dp;
  logic [4*DIGITS-1:0]  display;
  logic [DIGITS-1:0]    display_dp;
  logic                 pending;

  logic [DIGITS-1:0]    lz_mask;
  logic                 upper_zero;
  logic [3:0]           nibble_next;
  logic [6:0]           seg_next;
  logic                 dp_next;
  logic [DIGITS-1:0]    en_next;

  // Hex digit to segment pattern, active high, bit0 = a .. bit6 = g.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] pattern;
    case (nib)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

  // Slot counter and digit index advance together; both freeze while ena is low.
  always_comb begin
    count_next = count;
    index_next = index;
    slot_wrap  = ena && (count == LAST_COUNT);
    frame_wrap = slot_wrap && (index == LAST_INDEX);
    if (ena) begin
      if (count == LAST_COUNT) begin
        count_next = '0;
        index_next = (index == LAST_INDEX) ? '0 : index + IW'(1);
      end else begin
        count_next = count + CW'(1);
      end
    end
    last_next = ena && (count_next == LAST_COUNT) && (index_next == LAST_INDEX);
  end

  // Dead time opens each slot; the digit lights once the count reaches BLANK_CYCLES.
  always_comb begin
    state_next = state;
    if (ena) begin
      case (state)
        BLANK: if (count_next == SHOW_START) state_next = SHOW;
        SHOW:  if (slot_wrap)                state_next = BLANK;
      endcase
    end
  end

  // A digit is a leading zero when it and every digit to its left hold zero.
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (display[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_blank && upper_zero;
    end
  end

  // Active-high pin values for the cycle after this edge, taken from the next scan position.
  always_comb begin
    en_next     = '0;
    seg_next    = 7'h00;
    dp_next     = 1'b0;
    nibble_next = display[4*int'(index_next) +: 4];
    if (ena && (state_next == SHOW)) begin
      en_next  = DIGITS'(1) << index_next;
      dp_next  = display_dp[index_next];
      seg_next = lz_mask[index_next] ? 7'h00 : decode_hex(nibble_next);
    end
  end

  // Scan state, shadow/display handover and registered pin drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      index      <= '0;
      state      <= BLANK;
      shadow     <= '0;
      shadow_dp  <= '0;
      display    <= '0;
      display_dp <= '0;
      pending    <= 1'b0;
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
      digit_en   <= EN_OFF;
      frame_done <= 1'b0;
    end else begin
      count <= count_next;
      index <= index_next;
      state <= state_next;

      if (load) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
      end

      if (frame_wrap) begin
        if (load) begin
          display    <= value_in;
          display_dp <= dp_in;
        end else if (pending) begin
          display    <= shadow;
          display_dp <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      seg_out    <= seg_next ^ SEG_OFF;
      dp_out     <= dp_next ^ DP_OFF;
      digit_en   <= en_next ^ EN_OFF;
      frame_done <= last_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux
// Self-checking bench for seg_scan_mux (4 digits, 8-clock slots, 2 dead cycles).
// A frame-position model predicts every output cycle; directed scenarios add
// fixed expectations taken from the segment table.
`timescale 1ns/1ps
module tb_seg_scan_mux;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;
  localparam logic [12:0] CA_FLIP = 13'b1111111_1_1111_0;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        ena      = 1'b0;
  logic        load     = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dp_in    = 4'h0;

  logic [6:0]  seg_out,  seg_ca;
  logic        dp_out,   dp_ca;
  logic [3:0]  digit_en, en_ca;
  logic        frame_done, fd_ca;

  int checks = 0;
  int fails  = 0;

  // Model state: position inside the frame plus the value pipeline.
  int          m_pos;
  logic        m_act;
  logic        m_lz;
  logic        m_pend;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic [3:0]  m_dpd;
  logic [3:0]  m_shadow_dp;
  logic [6:0]  seg_table [16];

  seg_scan_mux #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES), .COMMON_ANODE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .value_in(value_in), .dp_in(dp_in), .load(load),
    .lz_blank(lz_blank), .seg_out(seg_out), .dp_out(dp_out), .digit_en(digit_en),
    .frame_done(frame_done)
  );

  seg_scan_mux #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES), .COMMON_ANODE(1'b1)
  ) dut_ca (
    .clk(clk), .rst(rst), .ena(ena), .value_in(value_in), .dp_in(dp_in), .load(load),
    .lz_blank(lz_blank), .seg_out(seg_ca), .dp_out(dp_ca), .digit_en(en_ca),
    .frame_done(fd_ca)
  );

  always #5 clk = ~clk;

  // Model: value handover happens on the edge that leaves the last cycle of a frame.
  always @(posedge clk) begin
    if (!rst) begin
      if (ena && m_pos == FRAME - 1) begin
        if (load) begin
          m_disp = value_in;
          m_dpd  = dp_in;
        end else if (m_pend) begin
          m_disp = m_shadow;
          m_dpd  = m_shadow_dp;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      if (load) begin
        m_shadow    = value_in;
        m_shadow_dp = dp_in;
      end
      if (ena) m_pos = (m_pos + 1) % FRAME;
      m_act = ena;
      m_lz  = lz_blank;
    end
  end

  function automatic logic [12:0] model_out();
    int d, s;
    logic [3:0] nib;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic       fd;
    d = m_pos / SCAN_DIV;
    s = m_pos % SCAN_DIV;
    seg = 7'h00; dp = 1'b0; en = 4'h0; fd = 1'b0;
    if (m_act) begin
      fd = (m_pos == FRAME - 1);
      if (s >= BLANK_CYCLES) begin
        en  = 4'(1 << d);
        dp  = m_dpd[d];
        nib = m_disp[4*d +: 4];
        if (m_lz && d > 0 && (m_disp >> (4*d)) == 16'h0) seg = 7'h00;
        else seg = seg_table[nib];
      end
    end
    return {seg, dp, en, fd};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_act = 1'b0; m_lz = 1'b0; m_pend = 1'b0;
    m_disp = 16'h0; m_shadow = 16'h0; m_dpd = 4'h0; m_shadow_dp = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic align_frame_end();
    int n = 0;
    while (m_pos != FRAME - 1 && n < 4 * FRAME) begin
      tick();
      n++;
    end
    checks++;
    if (m_pos != FRAME - 1) begin
      fails++;
      $display("[TB] FAIL align_timeout pos=%0d required=%0d", m_pos, FRAME - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (seg_out !== 7'h00) begin fails++; $display("[TB] FAIL reset_seg got=%h exp=00", seg_out); end
    checks++; if (digit_en !== 4'b0000) begin fails++; $display("[TB] FAIL reset_en got=%b exp=0000", digit_en); end
    checks++; if (dp_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_dp got=%b exp=0", dp_out); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_fd got=%b exp=0", frame_done); end
    checks++; if (seg_ca !== 7'h7F) begin fails++; $display("[TB] FAIL reset_ca_seg got=%h exp=7f", seg_ca); end
    checks++; if (en_ca !== 4'b1111) begin fails++; $display("[TB] FAIL reset_ca_en got=%b exp=1111", en_ca); end
    checks++; if (dp_ca !== 1'b1) begin fails++; $display("[TB] FAIL reset_ca_dp got=%b exp=1", dp_ca); end
    checks++; if (fd_ca !== 1'b0) begin fails++; $display("[TB] FAIL reset_ca_fd got=%b exp=0", fd_ca); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;
    tick();
    checks++; if (digit_en !== 4'b0000) begin fails++; $display("[TB] FAIL latency_blank got=%b exp=0000", digit_en); end
    tick();
    checks++; if (digit_en !== 4'b0001) begin fails++; $display("[TB] FAIL latency_en got=%b exp=0001", digit_en); end
    checks++; if (seg_out !== 7'h3F) begin fails++; $display("[TB] FAIL latency_seg got=%h exp=3f", seg_out); end
    checks++; if (seg_ca !== 7'h40 || en_ca !== 4'b1110) begin fails++; $display("[TB] FAIL latency_ca got=%h/%b exp=40/1110", seg_ca, en_ca); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    int fd_count = 0;
    int blank_count = 0;
    exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    value_in = 16'h1234; dp_in = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    align_frame_end();
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if ({seg_out, dp_out, digit_en, frame_done} !== model_out()) begin
        fails++;
        $display("[TB] FAIL scan_model c=%0d got=%h exp=%h", c, {seg_out, dp_out, digit_en, frame_done}, model_out());
      end
      if (frame_done) fd_count++;
      if (digit_en == 4'b0000) blank_count++;
      if (c % SCAN_DIV == BLANK_CYCLES) begin
        checks++;
        if (seg_out !== exp_seg[(c % FRAME) / SCAN_DIV] || digit_en !== 4'(1 << ((c % FRAME) / SCAN_DIV))) begin
          fails++;
          $display("[TB] FAIL scan_digit c=%0d got=%h/%b exp=%h", c, seg_out, digit_en, exp_seg[(c % FRAME) / SCAN_DIV]);
        end
      end
    end
    checks++; if (fd_count != 2) begin fails++; $display("[TB] FAIL scan_fd_count got=%0d exp=2", fd_count); end
    checks++; if (blank_count != 16) begin fails++; $display("[TB] FAIL scan_blank_count got=%0d exp=16", blank_count); end
  endtask

  task automatic test_tear_free();
    for (int c = 0; c < 3 * FRAME; c++) begin
      load     = (c == 12 || c == 64);
      value_in = (c == 64) ? 16'h5678 : 16'h9999;
      dp_in    = (c == 64) ? 4'b0010 : 4'b0000;
      tick();
      checks++;
      if ({seg_out, dp_out, digit_en, frame_done} !== model_out()) begin
        fails++;
        $display("[TB] FAIL tear_model c=%0d got=%h exp=%h", c, {seg_out, dp_out, digit_en, frame_done}, model_out());
      end
      if (c == 18) begin checks++; if (seg_out !== 7'h5B) begin fails++; $display("[TB] FAIL tear_old_d2 got=%h exp=5b", seg_out); end end
      if (c == 26) begin checks++; if (seg_out !== 7'h06) begin fails++; $display("[TB] FAIL tear_old_d3 got=%h exp=06", seg_out); end end
      if (c == 34) begin checks++; if (seg_out !== 7'h6F) begin fails++; $display("[TB] FAIL tear_new_d0 got=%h exp=6f", seg_out); end end
      if (c == 66) begin checks++; if (seg_out !== 7'h7F || dp_out !== 1'b0) begin fails++; $display("[TB] FAIL tear_fd_load_d0 got=%h/%b exp=7f/0", seg_out, dp_out); end end
      if (c == 74) begin checks++; if (seg_out !== 7'h07 || dp_out !== 1'b1) begin fails++; $display("[TB] FAIL tear_fd_load_d1 got=%h/%b exp=07/1", seg_out, dp_out); end end
    end
    load = 1'b0;
  endtask

  task automatic test_lz_blank();
    lz_blank = 1'b1;
    dp_in    = 4'h0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      load     = (c == 0 || c == 40);
      value_in = (c == 0) ? 16'h0050 : 16'h0000;
      tick();
      checks++;
      if ({seg_out, dp_out, digit_en, frame_done} !== model_out()) begin
        fails++;
        $display("[TB] FAIL lz_model c=%0d got=%h exp=%h", c, {seg_out, dp_out, digit_en, frame_done}, model_out());
      end
      if (c == 2)  begin checks++; if (seg_out !== 7'h3F || digit_en !== 4'b0001) begin fails++; $display("[TB] FAIL lz_d0 got=%h/%b exp=3f/0001", seg_out, digit_en); end end
      if (c == 10) begin checks++; if (seg_out !== 7'h6D || digit_en !== 4'b0010) begin fails++; $display("[TB] FAIL lz_d1 got=%h/%b exp=6d/0010", seg_out, digit_en); end end
      if (c == 18) begin checks++; if (seg_out !== 7'h00 || digit_en !== 4'b0100) begin fails++; $display("[TB] FAIL lz_d2 got=%h/%b exp=00/0100", seg_out, digit_en); end end
      if (c == 26) begin checks++; if (seg_out !== 7'h00 || digit_en !== 4'b1000) begin fails++; $display("[TB] FAIL lz_d3 got=%h/%b exp=00/1000", seg_out, digit_en); end end
      if (c == 66) begin checks++; if (seg_out !== 7'h3F) begin fails++; $display("[TB] FAIL lz_zero_d0 got=%h exp=3f", seg_out); end end
      if (c == 74) begin checks++; if (seg_out !== 7'h00 || digit_en !== 4'b0010) begin fails++; $display("[TB] FAIL lz_zero_d1 got=%h/%b exp=00/0010", seg_out, digit_en); end end
    end
    load     = 1'b0;
    lz_blank = 1'b0;
  endtask

  task automatic test_ena_pause();
    for (int c = 0; c < 12; c++) tick();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (digit_en !== 4'b0000 || seg_out !== 7'h00 || frame_done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL pause_inactive i=%0d got=%h/%b exp=00/0000", i, seg_out, digit_en);
      end
    end
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (digit_en !== 4'b0010 || {seg_out, dp_out, digit_en, frame_done} !== model_out()) begin
        fails++;
        $display("[TB] FAIL pause_resume i=%0d got=%h exp=%h en=%b", i, {seg_out, dp_out, digit_en, frame_done}, model_out(), digit_en);
      end
    end
    tick();
    checks++;
    if (digit_en !== 4'b0000) begin fails++; $display("[TB] FAIL pause_next_slot got=%b exp=0000", digit_en); end
  endtask

  task automatic test_reset_mid();
    align_frame_end();
    for (int c = 0; c < 20; c++) tick();
    value_in = 16'h4321; load = 1'b1;
    tick();
    load = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (seg_out !== 7'h00 || digit_en !== 4'b0000 || seg_ca !== 7'h7F || en_ca !== 4'b1111) begin
      fails++;
      $display("[TB] FAIL midrst_inactive got=%h/%b ca=%h/%b exp=00/0000 ca=7f/1111", seg_out, digit_en, seg_ca, en_ca);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (seg_out !== 7'h3F || digit_en !== 4'b0001) begin fails++; $display("[TB] FAIL midrst_d0 got=%h/%b exp=3f/0001", seg_out, digit_en); end
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if ({seg_out, dp_out, digit_en, frame_done} !== model_out()) begin
        fails++;
        $display("[TB] FAIL midrst_model c=%0d got=%h exp=%h", c, {seg_out, dp_out, digit_en, frame_done}, model_out());
      end
    end
    checks++;
    if (seg_out !== 7'h3F || digit_en !== 4'b0010) begin fails++; $display("[TB] FAIL midrst_discard got=%h/%b exp=3f/0010", seg_out, digit_en); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ena      = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 6) == 0);
      value_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in    = 4'($urandom);
      lz_blank = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({seg_out, dp_out, digit_en, frame_done} !== model_out()) begin
        fails++;
        $display("[TB] FAIL rand_model c=%0d got=%h exp=%h", c, {seg_out, dp_out, digit_en, frame_done}, model_out());
      end
      checks++;
      if ({seg_ca, dp_ca, en_ca, fd_ca} !== (model_out() ^ CA_FLIP)) begin
        fails++;
        $display("[TB] FAIL rand_ca c=%0d got=%h exp=%h", c, {seg_ca, dp_ca, en_ca, fd_ca}, model_out() ^ CA_FLIP);
      end
    end
    load = 1'b0;
    ena  = 1'b1;
  endtask

  initial begin
    seg_table = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    #1;
    test_reset();
    test_scan();
    test_tear_free();
    test_lz_blank();
    test_ena_pause();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
